match_referee: RTL and testbench

MATCH_REFEREE -- requirements
Module: match_referee

---
 rtl/match_referee.sv | 146 ++++++++++++++
 tb/tb_match_referee.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/match_referee.sv
// match_referee: round-based referee that awards a point to the sole player pressing on a lit target, first to WINS_NEEDED ends the match.
// Latency: round_win/round_tie/scores update one cycle after a qualifying press. Backpressure: none; inputs are ignored outside PLAY.
// Option: define MATCH_REFEREE_EDGE_EN to score on rising edges of press instead of its level.
module match_referee #(
  parameter int N_PLAYERS   = 2,
  parameter int WINS_NEEDED = 3,
  parameter int COOLDOWN    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_PLAYERS-1:0]   hit_zone,
  input  logic [N_PLAYERS-1:0]   press,
  output logic                   round_win,
  output logic                   round_tie,
  output logic [2:0]             round_winner,
  output logic [4*N_PLAYERS-1:0] scores,
  output logic                   match_over,
  output logic [6:0]             HEX0
);

  typedef enum logic [1:0] {PLAY, PAUSE, DONE} state_t;

  localparam logic [3:0] WIN4    = 4'(WINS_NEEDED);
  localparam logic [7:0] CD_LOAD = 8'(COOLDOWN - 1);

  state_t                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [4*N_PLAYERS-1:0]   scores_q;
  logic [N_PLAYERS-1:0]     press_evt;
  logic [N_PLAYERS-1:0]     qual;
  logic [3:0]               n_qual;
  logic [2:0]               win_idx;
  logic [3:0]               cur_score;
  logic                     win_d, tie_d, award;
  logic [6:0]               seg;

`ifdef MATCH_REFEREE_EDGE_EN
  logic [N_PLAYERS-1:0] prev_press;

  // History tracks press in every state so a button held through PAUSE cannot re-score.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev_press <= '0;
    else        prev_press <= press;
  end

  assign press_evt = press & ~prev_press;
`else
  assign press_evt = press;
`endif

  assign qual = hit_zone & press_evt;

  always_comb begin
    n_qual    = 4'd0;
    win_idx   = 3'd0;
    cur_score = 4'd0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (qual[i]) begin
        n_qual    = n_qual + 4'd1;
        win_idx   = 3'(i);
        cur_score = scores_q[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PLAY;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = 1'b0;
    tie_d   = 1'b0;
    award   = 1'b0;
    case (state_q)
      PLAY: begin
        if (n_qual == 4'd1) begin
          award = 1'b1;
          win_d = 1'b1;
          if (cur_score + 4'd1 >= WIN4) begin
            state_d = DONE;
          end else begin
            state_d = PAUSE;
            cnt_d   = CD_LOAD;
          end
        end else if (n_qual > 4'd1) begin
          tie_d   = 1'b1;
          state_d = PAUSE;
          cnt_d   = CD_LOAD;
        end
      end
      // Counter loaded with COOLDOWN-1 on entry, so PAUSE lasts COOLDOWN cycles.
      PAUSE: begin
        if (cnt_q == 8'd0) state_d = PLAY;
        else               cnt_d   = cnt_q - 8'd1;
      end
      DONE:    state_d = DONE;
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      round_win    <= 1'b0;
      round_tie    <= 1'b0;
      round_winner <= 3'd0;
      scores_q     <= '0;
    end else begin
      round_win <= win_d;
      round_tie <= tie_d;
      if (award) begin
        round_winner <= win_idx;
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (qual[i]) scores_q[4*i +: 4] <= scores_q[4*i +: 4] + 4'd1;
        end
      end
    end
  end

  always_comb begin
    seg = 7'b1111111;
    case (round_winner)
      3'd0: seg = ~7'b0000110;
      3'd1: seg = ~7'b1011011;
      3'd2: seg = ~7'b1001111;
      3'd3: seg = ~7'b1100110;
      3'd4: seg = ~7'b1101101;
      3'd5: seg = ~7'b1111101;
      3'd6: seg = ~7'b0000111;
      3'd7: seg = ~7'b1111111;
      default: seg = 7'b1111111;
    endcase
  end

  assign scores     = scores_q;
  assign match_over = (state_q == DONE);
  assign HEX0       = (state_q == DONE) ? seg : 7'b1111111;

endmodule

// File: tb/tb_match_referee.sv
// Directed bench for match_referee with N_PLAYERS=2, WINS_NEEDED=3, COOLDOWN=4.
module tb_match_referee;

  logic       clk;
  logic       reset;
  logic [1:0] hit_zone;
  logic [1:0] press;
  logic       round_win;
  logic       round_tie;
  logic [2:0] round_winner;
  logic [7:0] scores;
  logic       match_over;
  logic [6:0] HEX0;

  int n_cmp = 0;
  int n_err = 0;

  match_referee #(
    .N_PLAYERS  (2),
    .WINS_NEEDED(3),
    .COOLDOWN   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hit_zone    (hit_zone),
    .press       (press),
    .round_win   (round_win),
    .round_tie   (round_tie),
    .round_winner(round_winner),
    .scores      (scores),
    .match_over  (match_over),
    .HEX0        (HEX0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] hz, input logic [1:0] pr);
    hit_zone = hz;
    press    = pr;
  endtask

  initial begin
    reset = 1'b0;
    drive(2'b00, 2'b00);
    #1;
    chk("rst_win",    round_win,    0);
    chk("rst_tie",    round_tie,    0);
    chk("rst_scores", scores,       8'h00);
    chk("rst_winner", round_winner, 0);
    chk("rst_over",   match_over,   0);
    chk("rst_hex",    HEX0,         7'b1111111);
    tick();
    tick();
    reset = 1'b1;

    // Press without a lit target, and lit target of the wrong player
    drive(2'b00, 2'b01); tick();
    chk("nohit_win", round_win, 0);
    chk("nohit_scores", scores, 8'h00);
    drive(2'b10, 2'b01); tick();
    chk("wrongzone_win", round_win, 0);
    chk("wrongzone_tie", round_tie, 0);
    chk("wrongzone_scores", scores, 8'h00);
    drive(2'b00, 2'b00); tick();

    // Player 0 scores first point
    drive(2'b01, 2'b01); tick();
    chk("p0_win", round_win, 1);
    chk("p0_winner", round_winner, 0);
    chk("p0_scores", scores, 8'h01);
    chk("p0_hex", HEX0, 7'b1111111);
    chk("p0_over", match_over, 0);

    // PAUSE ignores inputs for four cycles
    drive(2'b11, 2'b11);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pause_win", round_win, 0);
      chk("pause_tie", round_tie, 0);
    end
    drive(2'b00, 2'b00); tick();
    chk("pause_last_win", round_win, 0);
    chk("pause_scores", scores, 8'h01);

    // Tie on the first PLAY cycle after PAUSE
    drive(2'b11, 2'b11); tick();
    chk("tie_pulse", round_tie, 1);
    chk("tie_nowin", round_win, 0);
    chk("tie_scores", scores, 8'h01);
    drive(2'b00, 2'b00); tick();
    chk("tie_one_cycle", round_tie, 0);
    for (int i = 0; i < 3; i++) tick();

    // Player 1 wins three rounds
    drive(2'b10, 2'b10); tick();
    chk("p1a_win", round_win, 1);
    chk("p1a_winner", round_winner, 1);
    chk("p1a_scores", scores, 8'h11);
    drive(2'b00, 2'b00);
    for (int i = 0; i < 4; i++) tick();
    drive(2'b10, 2'b10); tick();
    chk("p1b_scores", scores, 8'h21);
    chk("p1b_over", match_over, 0);
    drive(2'b00, 2'b00);
    for (int i = 0; i < 4; i++) tick();
    drive(2'b10, 2'b10); tick();
    chk("p1c_win", round_win, 1);
    chk("p1c_scores", scores, 8'h31);
    chk("p1c_over", match_over, 1);
    chk("p1c_hex", HEX0, 7'b0100100);
    drive(2'b00, 2'b00); tick();
    chk("done_pulse_end", round_win, 0);
    drive(2'b11, 2'b11); tick();
    chk("done_nowin", round_win, 0);
    chk("done_notie", round_tie, 0);
    drive(2'b01, 2'b01); tick();
    chk("done_nowin2", round_win, 0);
    chk("done_scores", scores, 8'h31);
    chk("done_hex", HEX0, 7'b0100100);
    chk("done_winner", round_winner, 1);

    // Asynchronous reset while in DONE
    drive(2'b00, 2'b00);
    #3 reset = 1'b0;
    #1;
    chk("rdone_over", match_over, 0);
    chk("rdone_hex", HEX0, 7'b1111111);
    chk("rdone_scores", scores, 8'h00);
    chk("rdone_winner", round_winner, 0);
    tick();
    reset = 1'b1;

    // Asynchronous reset mid-PAUSE
    drive(2'b01, 2'b01); tick();
    chk("mp_scores", scores, 8'h01);
    drive(2'b00, 2'b00);
    tick();
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mp_rst_scores", scores, 8'h00);
    chk("mp_rst_win", round_win, 0);
    chk("mp_rst_over", match_over, 0);
    chk("mp_rst_hex", HEX0, 7'b1111111);
    tick();
    reset = 1'b1;
    tick();
    chk("mp_no_residual_win", round_win, 0);
    chk("mp_no_residual_tie", round_tie, 0);
    drive(2'b10, 2'b10); tick();
    chk("mp_play_win", round_win, 1);
    chk("mp_play_scores", scores, 8'h10);
    chk("mp_play_winner", round_winner, 1);

    // Held button across two PLAY windows
    drive(2'b00, 2'b00);
    #2 reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(2'b01, 2'b01); tick();
    chk("hold_first_win", round_win, 1);
    chk("hold_first_scores", scores, 8'h01);
    for (int i = 0; i < 4; i++) tick();
    tick();
`ifdef MATCH_REFEREE_EDGE_EN
    chk("hold_second_win", round_win, 0);
    chk("hold_second_scores", scores, 8'h01);
`else
    chk("hold_second_win", round_win, 1);
    chk("hold_second_scores", scores, 8'h02);
`endif
    drive(2'b00, 2'b00); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
